// File: rtl/alu_issue_stage_if.sv
// ============================================================================
// Module   : alu_issue_stage_if
// Brief    : Decode-side and execute-side handshake bundle for alu_issue_stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface alu_issue_stage_if #(
  parameter int XLEN = 64
);
  logic            ValidD;
  logic            ReadyD;
  logic [31:0]     InstrD;
  logic [XLEN-1:0] RD1D;
  logic [XLEN-1:0] RD2D;
  logic            FlushE;
  logic            ValidE;
  logic            ReadyE;
  logic [XLEN-1:0] SrcAE;
  logic [XLEN-1:0] SrcBE;
  logic [3:0]      ALUControlE;
  logic [2:0]      funct3E;
  logic            BranchE;
  logic            RegWriteE;
  logic [4:0]      RdE;
  logic            IllegalE;

  modport master (
    output ValidD, InstrD, RD1D, RD2D, FlushE, ReadyE,
    input  ReadyD, ValidE, SrcAE, SrcBE, ALUControlE, funct3E,
           BranchE, RegWriteE, RdE, IllegalE
  );

  modport slave (
    input  ValidD, InstrD, RD1D, RD2D, FlushE, ReadyE,
    output ReadyD, ValidE, SrcAE, SrcBE, ALUControlE, funct3E,
           BranchE, RegWriteE, RdE, IllegalE
  );
endinterface

`default_nettype wire

// File: rtl/alu_issue_stage.sv
// ============================================================================
// Module   : alu_issue_stage
// Brief    : Decodes RV64 ALU/branch instructions into ALU controls and holds
//            them in a head + skid buffer toward the execute stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_issue_stage #(
  parameter int XLEN       = 64,
  parameter bit ENABLE_ZBA = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  alu_issue_stage_if.slave bus
);

  localparam logic [3:0] C_ALU_ADD    = 4'b0000;
  localparam logic [3:0] C_ALU_SUB    = 4'b0001;
  localparam logic [3:0] C_ALU_AND    = 4'b0010;
  localparam logic [3:0] C_ALU_OR     = 4'b0011;
  localparam logic [3:0] C_ALU_SLT    = 4'b0100;
  localparam logic [3:0] C_ALU_XOR    = 4'b0101;
  localparam logic [3:0] C_ALU_SH1ADD = 4'b1000;
  localparam logic [3:0] C_ALU_SH2ADD = 4'b1001;
  localparam logic [3:0] C_ALU_SH3ADD = 4'b1010;
  localparam logic [3:0] C_ALU_ADDUW  = 4'b1011;

  typedef struct packed {
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic [3:0]      alu_ctrl;
    logic [2:0]      funct3;
    logic            branch;
    logic            reg_write;
    logic [4:0]      rd;
    logic            illegal;
  } entry_t;

  entry_t w_dec;
  entry_t head_q, head_d, skid_q, skid_d;
  logic   head_valid_q, head_valid_d;
  logic   skid_valid_q, skid_valid_d;
  logic   w_accept, w_pop;

  logic [6:0] w_opcode;
  logic [2:0] w_f3;
  logic [6:0] w_f7;
  logic       unused_rs1_field;

  assign w_opcode         = bus.InstrD[6:0];
  assign w_f3             = bus.InstrD[14:12];
  assign w_f7             = bus.InstrD[31:25];
  assign unused_rs1_field = ^bus.InstrD[19:15];

  // Decode defaults to illegal; each legal encoding clears the flag.
  always_comb begin
    w_dec           = '0;
    w_dec.src_a     = bus.RD1D;
    w_dec.src_b     = bus.RD2D;
    w_dec.funct3    = w_f3;
    w_dec.illegal   = 1'b1;
    unique case (w_opcode)
      7'b0110011: begin
        if (w_f7 == 7'b0000000) begin
          w_dec.illegal = 1'b0;
          case (w_f3)
            3'b000:  w_dec.alu_ctrl = C_ALU_ADD;
            3'b010:  w_dec.alu_ctrl = C_ALU_SLT;
            3'b100:  w_dec.alu_ctrl = C_ALU_XOR;
            3'b110:  w_dec.alu_ctrl = C_ALU_OR;
            3'b111:  w_dec.alu_ctrl = C_ALU_AND;
            default: w_dec.illegal  = 1'b1;
          endcase
        end else if (w_f7 == 7'b0100000 && w_f3 == 3'b000) begin
          w_dec.illegal  = 1'b0;
          w_dec.alu_ctrl = C_ALU_SUB;
        end else if (w_f7 == 7'b0010000 && ENABLE_ZBA) begin
          w_dec.illegal = 1'b0;
          w_dec.src_a   = bus.RD2D;
          w_dec.src_b   = bus.RD1D;
          case (w_f3)
            3'b010:  w_dec.alu_ctrl = C_ALU_SH1ADD;
            3'b100:  w_dec.alu_ctrl = C_ALU_SH2ADD;
            3'b110:  w_dec.alu_ctrl = C_ALU_SH3ADD;
            default: w_dec.illegal  = 1'b1;
          endcase
        end
      end
      7'b0111011: begin
        if (w_f7 == 7'b0000100 && w_f3 == 3'b000 && ENABLE_ZBA) begin
          w_dec.illegal  = 1'b0;
          w_dec.alu_ctrl = C_ALU_ADDUW;
          w_dec.src_a    = bus.RD2D;
          w_dec.src_b    = bus.RD1D;
        end
      end
      7'b0010011: begin
        w_dec.illegal = 1'b0;
        w_dec.src_b   = {{(XLEN-12){bus.InstrD[31]}}, bus.InstrD[31:20]};
        case (w_f3)
          3'b000:  w_dec.alu_ctrl = C_ALU_ADD;
          3'b010:  w_dec.alu_ctrl = C_ALU_SLT;
          3'b100:  w_dec.alu_ctrl = C_ALU_XOR;
          3'b110:  w_dec.alu_ctrl = C_ALU_OR;
          3'b111:  w_dec.alu_ctrl = C_ALU_AND;
          default: w_dec.illegal  = 1'b1;
        endcase
      end
      7'b1100011: begin
        if (w_f3 inside {3'b000, 3'b001, 3'b100, 3'b101}) begin
          w_dec.illegal  = 1'b0;
          w_dec.branch   = 1'b1;
          w_dec.alu_ctrl = C_ALU_SUB;
        end
      end
      default: ;
    endcase
    if (w_dec.illegal) begin
      w_dec.alu_ctrl = C_ALU_ADD;
      w_dec.branch   = 1'b0;
    end
    w_dec.reg_write = !w_dec.illegal && !w_dec.branch;
    w_dec.rd        = w_dec.reg_write ? bus.InstrD[11:7] : 5'd0;
  end

  assign w_accept = bus.ValidD && !skid_valid_q;
  assign w_pop    = head_valid_q && bus.ReadyE;

  // Head only changes on pop or fill-from-empty, so data holds under stall.
  always_comb begin
    head_d       = head_q;
    skid_d       = skid_q;
    head_valid_d = head_valid_q;
    skid_valid_d = skid_valid_q;
    if (bus.FlushE) begin
      head_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (w_pop) begin
      if (skid_valid_q) begin
        head_d       = skid_q;
        skid_valid_d = 1'b0;
      end else if (w_accept) begin
        head_d = w_dec;
      end else begin
        head_valid_d = 1'b0;
      end
    end else if (w_accept) begin
      if (head_valid_q) begin
        skid_d       = w_dec;
        skid_valid_d = 1'b1;
      end else begin
        head_d       = w_dec;
        head_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q       <= '0;
      skid_q       <= '0;
      head_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      head_q       <= head_d;
      skid_q       <= skid_d;
      head_valid_q <= head_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign bus.ReadyD      = !skid_valid_q;
  assign bus.ValidE      = head_valid_q;
  assign bus.SrcAE       = head_q.src_a;
  assign bus.SrcBE       = head_q.src_b;
  assign bus.ALUControlE = head_q.alu_ctrl;
  assign bus.funct3E     = head_q.funct3;
  assign bus.BranchE     = head_valid_q && head_q.branch;
  assign bus.RegWriteE   = head_valid_q && head_q.reg_write;
  assign bus.RdE         = head_q.rd;
  assign bus.IllegalE    = head_q.illegal;

endmodule

`default_nettype wire

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Decode-to-execute issue stage: decodes a 32-bit RV64 instruction plus register-file operands into the execute-stage ALU interface (SrcAE, SrcBE, ALUControlE, funct3E, BranchE).
- Holds issued operations in a 2-entry skid buffer with valid/ready handshakes on both sides.
- Sits between the decode stage/register file and the execute-stage ALU; it is the producer end of the ALU control encoding.

Parameters:
- XLEN, 64, operand width.
- ENABLE_ZBA, 1, when 0 the Zba encodings decode as illegal.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- ValidD  input  1  upstream beat valid
- ReadyD  output  1  stage can accept a beat
- InstrD  input  32  instruction word
- RD1D  input  XLEN  rs1 value
- RD2D  input  XLEN  rs2 value
- FlushE  input  1  discard all buffered beats
- ValidE  output  1  execute-side beat valid
- ReadyE  input  1  execute consumes the head beat
- SrcAE  output  XLEN  ALU operand A
- SrcBE  output  XLEN  ALU operand B
- ALUControlE  output  4  ALU operation code
- funct3E  output  3  InstrD[14:12] of the head beat
- BranchE  output  1  head beat is a conditional branch
- RegWriteE  output  1  head beat writes rd
- RdE  output  5  destination register
- IllegalE  output  1  head beat is an unsupported encoding

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- ALU codes: ADD=0000, SUB=0001, AND=0010, OR=0011, SLT=0100, XOR=0101, SH1ADD=1000, SH2ADD=1001, SH3ADD=1010, ADD.UW=1011.
- OP (0110011):
  - funct7=0000000: f3 000 ADD, 010 SLT, 100 XOR, 110 OR, 111 AND.
  - funct7=0100000 with f3 000: SUB.
  - SrcA=rs1, SrcB=rs2.
- OP Zba (0110011, funct7=0010000): f3 010/100/110 map to SH1ADD/SH2ADD/SH3ADD. Operands are swapped: SrcA=rs2, SrcB=rs1.
- OP-32 (0111011, funct7=0000100, f3 000): ADD.UW. SrcA=rs2, SrcB=rs1.
- OP-IMM (0010011): f3 000/010/100/110/111 map to ADD/SLT/XOR/OR/AND. SrcA=rs1, SrcB=sign-extended InstrD[31:20].
- BRANCH (1100011):
  - f3 000/001/100/101: ALUControl=SUB, BranchE=1, RegWriteE=0, SrcA=rs1, SrcB=rs2.
  - f3 110/111: illegal.
- RegWriteE=1 for every legal non-branch beat. RdE=InstrD[11:7] for those beats, 0 otherwise.
- Illegal beats (any other encoding, or Zba with ENABLE_ZBA=0):
  - IllegalE=1, ALUControl=0000, BranchE=0, RegWriteE=0.
  - The beat still flows through the buffer like any other.
- Buffer: head register (drives the E outputs) plus one skid entry.
  - ReadyD = !skid_valid, taken from a register, never combinational from ReadyE.
  - Accept when ValidD&&ReadyD. Pop when ValidE&&ReadyE.
  - Empty + accept: beat appears at the head next cycle (1-cycle latency).
  - Head valid, no pop, accept: beat goes to skid.
  - Pop + accept with skid empty: new beat goes to head.
  - Pop with skid full: skid moves to head. No accept is possible because ReadyD=0.
  - Order is strictly FIFO. No beat is lost or duplicated.
- FlushE (priority below reset, above all else): next cycle ValidE=0 and skid empty. Any beat accepted in the flush cycle is dropped.
- Reset and invalid outputs:
  - After reset, ValidE=0, skid_valid=0, ReadyD=1.
  - All data outputs (SrcAE, SrcBE, ALUControlE, funct3E, BranchE, RegWriteE, RdE, IllegalE) are 0.
  - Data outputs are held stable while ValidE&&!ReadyE.
  - BranchE and RegWriteE are forced 0 whenever ValidE=0.
- Reset mid-operation clears both entries regardless of ValidD, ReadyE or FlushE.

Test Plan:
- Reset, then `add x5,x1,x2` (0x002082B3) with RD1D=3, RD2D=4, ReadyE=1 → next cycle: ValidE=1, ALUControlE=0000, SrcAE=3, SrcBE=4, RdE=5, RegWriteE=1.
- `sh2add x3,x1,x2` (0x2020C1B3) with RD1D=5, RD2D=0x100 → SrcAE=0x100, SrcBE=5, ALUControlE=1001. `add.uw` (0x080080BB) gives ALUControlE=1011 with operands swapped. Same sh2add with ENABLE_ZBA=0 → IllegalE=1, RegWriteE=0.
- `blt x1,x2` (funct3=100) → BranchE=1, funct3E=100, ALUControlE=0001, RegWriteE=0. `bltu` (funct3=110) → IllegalE=1, BranchE=0.
- Backpressure: ReadyE=0 while 3 beats A,B,C are offered → A at head, B in skid, ReadyD=0 and C not accepted, outputs stable. Raise ReadyE → A, B, C exit in order, one per cycle.
- FlushE asserted with both entries full and ValidD=1 → next cycle ValidE=0, ReadyD=1, and the beat offered in the flush cycle never appears.
- Reset asserted with a full buffer and ReadyE=1 → next cycle ValidE=0, ReadyD=1, all outputs 0.
